// File: rtl/hazard_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_if
//  Description : ID-stage instruction in, stall and forwarding selects out,
//                between the datapath control and the hazard scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_if;
    logic [31:0] id_instr;
    logic        stall;
    logic [1:0]  fwd_rs_d;
    logic [1:0]  fwd_rt_d;
    logic [1:0]  fwd_rs_e;
    logic [1:0]  fwd_rt_e;
    logic [1:0]  fwd_rt_m;

    // Datapath side: presents the ID instruction, consumes the controls
    modport master (
        output id_instr,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
    );

    // Scoreboard side
    modport slave (
        input  id_instr,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Tuse/Tnew hazard unit for the 5-stage MIPS pipeline. Keeps a
//                shadow copy of producers in EX/MEM/WB and derives the ID
//                stall plus every forwarding-mux select.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int unsigned TNEW_ALU = 1,
    parameter int unsigned TNEW_DM  = 2
) (
    input  wire logic clk,
    input  wire logic reset_n,
    hazard_if.slave   hz
);
    // Result classes
    localparam logic [1:0] c_RES_NW    = 2'd0;
    localparam logic [1:0] c_RES_ALU   = 2'd1;
    localparam logic [1:0] c_RES_DM    = 2'd2;
    localparam logic [1:0] c_RES_PC    = 2'd3;
    localparam logic [1:0] c_TUSE_NONE = 2'd3;
    localparam logic [1:0] c_TNEW_ALU  = 2'(TNEW_ALU);
    localparam logic [1:0] c_TNEW_DM   = 2'(TNEW_DM);

    // Instruction fields of the ID-stage instruction
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_unused;

    assign w_op     = hz.id_instr[31:26];
    assign w_rs     = hz.id_instr[25:21];
    assign w_rt     = hz.id_instr[20:16];
    assign w_rd     = hz.id_instr[15:11];
    assign w_funct  = hz.id_instr[5:0];
    assign w_unused = &{1'b0, hz.id_instr[10:6]};

    // Decoded producer/consumer attributes
    logic [1:0] w_dec_res;
    logic [4:0] w_dec_dest;
    logic [1:0] w_dec_tnew;
    logic [1:0] w_tuse_rs;
    logic [1:0] w_tuse_rt;

    // Shadow pipeline entries
    logic [4:0] r_ex_rs, r_ex_rt, r_ex_dest;
    logic [1:0] r_ex_res, r_ex_tnew;
    logic [4:0] r_mem_rt, r_mem_dest;
    logic [1:0] r_mem_res, r_mem_tnew;
    logic [4:0] r_wb_dest;
    logic [1:0] r_wb_res, r_wb_tnew;

    // Hazard results
    logic [2:0] w_id_rs;
    logic [2:0] w_id_rt;
    logic       w_stall;
    logic [1:0] w_fwd_rs_e;
    logic [1:0] w_fwd_rt_e;
    logic [1:0] w_fwd_rt_m;

    function automatic logic [1:0] f_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic f_match(input logic [4:0] r, input logic [4:0] dest,
                                     input logic [1:0] res);
        return (r != 5'd0) && (res != c_RES_NW) && (dest == r);
    endfunction

    // ID operand check: {stall, fwd}. Only the nearest match is considered,
    // a not-yet-ready nearest producer blocks any older stage.
    function automatic logic [2:0] f_id_check(input logic [4:0] r, input logic [1:0] tuse);
        if (f_match(r, r_ex_dest, r_ex_res))
            return {(tuse != c_TUSE_NONE) && (r_ex_tnew > tuse),
                    ((r_ex_tnew == 2'd0) && (r_ex_res == c_RES_PC)) ? 2'd3 : 2'd0};
        else if (f_match(r, r_mem_dest, r_mem_res))
            return {(tuse != c_TUSE_NONE) && (r_mem_tnew > tuse),
                    (r_mem_tnew == 2'd0) ? 2'd1 : 2'd0};
        else if (f_match(r, r_wb_dest, r_wb_res))
            return {(tuse != c_TUSE_NONE) && (r_wb_tnew > tuse),
                    (r_wb_tnew == 2'd0) ? 2'd2 : 2'd0};
        else
            return 3'd0;
    endfunction

    // EX operand forwarding from MEM or WB
    function automatic logic [1:0] f_ex_fwd(input logic [4:0] r);
        if (f_match(r, r_mem_dest, r_mem_res))
            return (r_mem_tnew == 2'd0) ? 2'd1 : 2'd0;
        else if (f_match(r, r_wb_dest, r_wb_res))
            return (r_wb_tnew == 2'd0) ? 2'd2 : 2'd0;
        else
            return 2'd0;
    endfunction

    // Decode the ID instruction into producer class/dest and operand Tuse
    always_comb begin
        w_dec_res  = c_RES_NW;
        w_dec_dest = 5'd0;
        w_tuse_rs  = c_TUSE_NONE;
        w_tuse_rt  = c_TUSE_NONE;
        case (w_op)
            6'd0: begin
                if ((w_funct == 6'd33) || (w_funct == 6'd35)) begin
                    w_dec_res  = c_RES_ALU;
                    w_dec_dest = w_rd;
                    w_tuse_rs  = 2'd1;
                    w_tuse_rt  = 2'd1;
                end else if (w_funct == 6'd8) begin
                    w_tuse_rs  = 2'd0;
                end
            end
            6'd12, 6'd13: begin
                w_dec_res  = c_RES_ALU;
                w_dec_dest = w_rt;
                w_tuse_rs  = 2'd1;
            end
            6'd15: begin
                w_dec_res  = c_RES_ALU;
                w_dec_dest = w_rt;
            end
            6'd35: begin
                w_dec_res  = c_RES_DM;
                w_dec_dest = w_rt;
                w_tuse_rs  = 2'd1;
            end
            6'd43: begin
                w_tuse_rs  = 2'd1;
                w_tuse_rt  = 2'd2;
            end
            6'd4: begin
                w_tuse_rs  = 2'd0;
                w_tuse_rt  = 2'd0;
            end
            6'd3: begin
                w_dec_res  = c_RES_PC;
                w_dec_dest = 5'd31;
            end
            6'd16: begin
                if (w_rs == 5'd0) begin
                    w_dec_res  = c_RES_DM;
                    w_dec_dest = w_rt;
                end else if (w_rs == 5'd4) begin
                    w_tuse_rt  = 2'd2;
                end
            end
            default: ;
        endcase
    end

    // Initial Tnew of the decoded producer as it enters EX
    always_comb begin
        w_dec_tnew = 2'd0;
        if (w_dec_res == c_RES_ALU)
            w_dec_tnew = c_TNEW_ALU;
        else if (w_dec_res == c_RES_DM)
            w_dec_tnew = c_TNEW_DM;
    end

    // Stall and forwarding selects from the current shadow pipeline
    always_comb begin
        w_id_rs    = f_id_check(w_rs, w_tuse_rs);
        w_id_rt    = f_id_check(w_rt, w_tuse_rt);
        w_stall    = w_id_rs[2] | w_id_rt[2];
        w_fwd_rs_e = f_ex_fwd(r_ex_rs);
        w_fwd_rt_e = f_ex_fwd(r_ex_rt);
        w_fwd_rt_m = (f_match(r_mem_rt, r_wb_dest, r_wb_res) && (r_wb_tnew == 2'd0))
                     ? 2'd2 : 2'd0;
    end

    assign hz.stall    = w_stall;
    assign hz.fwd_rs_d = w_id_rs[1:0];
    assign hz.fwd_rt_d = w_id_rt[1:0];
    assign hz.fwd_rs_e = w_fwd_rs_e;
    assign hz.fwd_rt_e = w_fwd_rt_e;
    assign hz.fwd_rt_m = w_fwd_rt_m;

    // Advance the shadow pipeline; a stall injects a bubble into EX
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex_rs    <= 5'd0;
            r_ex_rt    <= 5'd0;
            r_ex_dest  <= 5'd0;
            r_ex_res   <= c_RES_NW;
            r_ex_tnew  <= 2'd0;
            r_mem_rt   <= 5'd0;
            r_mem_dest <= 5'd0;
            r_mem_res  <= c_RES_NW;
            r_mem_tnew <= 2'd0;
            r_wb_dest  <= 5'd0;
            r_wb_res   <= c_RES_NW;
            r_wb_tnew  <= 2'd0;
        end else begin
            r_wb_dest  <= r_mem_dest;
            r_wb_res   <= r_mem_res;
            r_wb_tnew  <= f_dec(r_mem_tnew);
            r_mem_rt   <= r_ex_rt;
            r_mem_dest <= r_ex_dest;
            r_mem_res  <= r_ex_res;
            r_mem_tnew <= f_dec(r_ex_tnew);
            if (w_stall) begin
                r_ex_rs   <= 5'd0;
                r_ex_rt   <= 5'd0;
                r_ex_dest <= 5'd0;
                r_ex_res  <= c_RES_NW;
                r_ex_tnew <= 2'd0;
            end else begin
                r_ex_rs   <= w_rs;
                r_ex_rt   <= w_rt;
                r_ex_dest <= w_dec_dest;
                r_ex_res  <= w_dec_res;
                r_ex_tnew <= w_dec_tnew;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench for hazard_scoreboard: directed
//                scenarios plus randomized instruction streams against an
//                age-based pipeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
    logic clk;
    logic reset_n;
    hazard_if hz ();

    hazard_scoreboard #(.TNEW_ALU(1), .TNEW_DM(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: stage k (0=EX,1=MEM,2=WB) holds class, dest, Tnew at EX entry,
    // raw rs/rt. Current Tnew = max(0, t0 - age).
    int m_cls[3], m_dest[3], m_t0[3], m_rs[3], m_rt[3];
    logic [31:0] cur;
    int e_stall, e_fd_rs, e_fd_rt, e_fe_rs, e_fe_rt, e_fm_rt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input int fn, input int rd, input int rs, input int rt);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_jr(input int rs);
        return {6'd0, 5'(rs), 15'd0, 6'd8};
    endfunction
    function automatic logic [31:0] enc_jal();
        return {6'd3, 26'h0000100};
    endfunction
    function automatic logic [31:0] enc_cp0(input int sel, input int rt, input int rd);
        return {6'd16, 5'(sel), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] rand_instr();
        int a, b, c;
        a = int'($urandom_range(0, 3));
        b = int'($urandom_range(0, 3));
        c = int'($urandom_range(0, 3));
        case ($urandom_range(0, 13))
            0:  return enc_r(33, a, b, c);
            1:  return enc_r(35, a, b, c);
            2:  return enc_jr(a == 0 ? 31 : a);
            3:  return enc_i(13, b, a, 7);
            4:  return enc_i(12, b, a, 3);
            5:  return enc_i(15, 0, a, 9);
            6:  return enc_i(35, b, a, 4);
            7:  return enc_i(43, b, a, 8);
            8:  return enc_i(4, a, b, 2);
            9:  return enc_jal();
            10: return enc_cp0(0, a, 12);
            11: return enc_cp0(4, a, 12);
            12: return 32'd0;
            default: return enc_i(2, a, b, 1);
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Class: 0 none, 1 ALU, 2 DM, 3 PC. Tuse 3 = operand not read.
    function automatic void m_decode(input logic [31:0] ins, output int cls, output int dest,
                                     output int tu_rs, output int tu_rt);
        int op, fn, rs, rt, rd;
        op = int'(ins[31:26]); fn = int'(ins[5:0]);
        rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
        cls = 0; dest = 0; tu_rs = 3; tu_rt = 3;
        if (op == 0 && (fn == 33 || fn == 35)) begin cls = 1; dest = rd; tu_rs = 1; tu_rt = 1; end
        else if (op == 0 && fn == 8)            tu_rs = 0;
        else if (op == 13 || op == 12)          begin cls = 1; dest = rt; tu_rs = 1; end
        else if (op == 15)                      begin cls = 1; dest = rt; end
        else if (op == 35)                      begin cls = 2; dest = rt; tu_rs = 1; end
        else if (op == 43)                      begin tu_rs = 1; tu_rt = 2; end
        else if (op == 4)                       begin tu_rs = 0; tu_rt = 0; end
        else if (op == 3)                       begin cls = 3; dest = 31; end
        else if (op == 16 && rs == 0)           begin cls = 2; dest = rt; end
        else if (op == 16 && rs == 4)           tu_rt = 2;
    endfunction

    function automatic int m_tnew(input int k);
        int t;
        t = m_t0[k] - k;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic int m_near(input int r, input int from);
        if (r == 0) return -1;
        for (int k = from; k < 3; k++)
            if (m_cls[k] != 0 && m_dest[k] == r) return k;
        return -1;
    endfunction

    function automatic int m_fd(input int r);
        int k;
        k = m_near(r, 0);
        if (k < 0 || m_tnew(k) != 0) return 0;
        if (k == 0) return (m_cls[0] == 3) ? 3 : 0;
        return k;
    endfunction

    function automatic int m_fe(input int r);
        int k;
        k = m_near(r, 1);
        return (k < 0 || m_tnew(k) != 0) ? 0 : k;
    endfunction

    task automatic m_eval();
        int cls, dest, tr, tt, rs, rt, k;
        m_decode(cur, cls, dest, tr, tt);
        rs = int'(cur[25:21]); rt = int'(cur[20:16]);
        e_stall = 0;
        k = m_near(rs, 0);
        if (tr != 3 && k >= 0 && m_tnew(k) > tr) e_stall = 1;
        k = m_near(rt, 0);
        if (tt != 3 && k >= 0 && m_tnew(k) > tt) e_stall = 1;
        e_fd_rs = m_fd(rs);
        e_fd_rt = m_fd(rt);
        e_fe_rs = m_fe(m_rs[0]);
        e_fe_rt = m_fe(m_rt[0]);
        k = m_near(m_rt[1], 2);
        e_fm_rt = (k >= 0 && m_tnew(k) == 0) ? 2 : 0;
    endtask

    task automatic m_advance();
        int cls, dest, tr, tt;
        for (int k = 2; k > 0; k--) begin
            m_cls[k] = m_cls[k-1]; m_dest[k] = m_dest[k-1]; m_t0[k] = m_t0[k-1];
            m_rs[k] = m_rs[k-1]; m_rt[k] = m_rt[k-1];
        end
        m_cls[0] = 0; m_dest[0] = 0; m_t0[0] = 0; m_rs[0] = 0; m_rt[0] = 0;
        if (e_stall == 0) begin
            m_decode(cur, cls, dest, tr, tt);
            m_cls[0]  = cls;
            m_dest[0] = dest;
            m_t0[0]   = (cls == 1) ? 1 : (cls == 2) ? 2 : 0;
            m_rs[0]   = int'(cur[25:21]);
            m_rt[0]   = int'(cur[20:16]);
        end
    endtask

    task automatic m_clear();
        for (int k = 0; k < 3; k++) begin
            m_cls[k] = 0; m_dest[k] = 0; m_t0[k] = 0; m_rs[k] = 0; m_rt[k] = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [31:0] ins);
        hz.id_instr = ins;
        cur = ins;
        @(negedge clk);
        m_eval();
    endtask

    task automatic tick();
        m_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        repeat (3) begin drive(32'd0); tick(); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        m_clear();
        hz.id_instr = enc_i(35, 0, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", hz.stall); end
        n_cmp++; if (hz.fwd_rs_d !== 2'd0) begin n_fail++; $display("FAIL reset_fwd_rs_d: got %0d want 0", hz.fwd_rs_d); end
        n_cmp++; if (hz.fwd_rs_e !== 2'd0) begin n_fail++; $display("FAIL reset_fwd_rs_e: got %0d want 0", hz.fwd_rs_e); end
        n_cmp++; if (hz.fwd_rt_m !== 2'd0) begin n_fail++; $display("FAIL reset_fwd_rt_m: got %0d want 0", hz.fwd_rt_m); end
        reset_n = 1'b1;
        // The lw held in ID during reset never entered EX
        drive(enc_r(33, 2, 1, 1));
        n_cmp++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL reset_no_entry_stall: got %0b want 0", hz.stall); end
        tick();
        flush();
    endtask

    task automatic test_load_use();
        drive(enc_i(35, 0, 1, 0));
        n_cmp++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL lu_first_stall: got %0b want 0", hz.stall); end
        tick();
        drive(enc_r(33, 2, 1, 1));
        n_cmp++; if (hz.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0b want 1", hz.stall); end
        tick();
        drive(enc_r(33, 2, 1, 1));
        n_cmp++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_release: got %0b want 0", hz.stall); end
        tick();
        drive(32'd0);
        n_cmp++; if (hz.fwd_rs_e !== 2'd2) begin n_fail++; $display("FAIL lu_fwd_rs_e: got %0d want 2", hz.fwd_rs_e); end
        n_cmp++; if (hz.fwd_rt_e !== 2'd2) begin n_fail++; $display("FAIL lu_fwd_rt_e: got %0d want 2", hz.fwd_rt_e); end
        tick();
        flush();
    endtask

    task automatic test_branch();
        drive(enc_i(13, 0, 3, 5));
        tick();
        drive(enc_i(4, 3, 0, 1));
        n_cmp++; if (hz.stall !== 1'b1) begin n_fail++; $display("FAIL br_stall: got %0b want 1", hz.stall); end
        tick();
        drive(enc_i(4, 3, 0, 1));
        n_cmp++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL br_stall_release: got %0b want 0", hz.stall); end
        n_cmp++; if (hz.fwd_rs_d !== 2'd1) begin n_fail++; $display("FAIL br_fwd_rs_d: got %0d want 1", hz.fwd_rs_d); end
        n_cmp++; if (hz.fwd_rt_d !== 2'd0) begin n_fail++; $display("FAIL br_fwd_rt_d: got %0d want 0", hz.fwd_rt_d); end
        tick();
        flush();
    endtask

    task automatic test_jal_jr();
        drive(enc_jal());
        tick();
        drive(enc_jr(31));
        n_cmp++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL jal_stall: got %0b want 0", hz.stall); end
        n_cmp++; if (hz.fwd_rs_d !== 2'd3) begin n_fail++; $display("FAIL jal_fwd_pc8: got %0d want 3", hz.fwd_rs_d); end
        tick();
        flush();
        drive(enc_jal());
        tick();
        drive(32'd0);
        tick();
        drive(enc_jr(31));
        n_cmp++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL jal_nop_stall: got %0b want 0", hz.stall); end
        n_cmp++; if (hz.fwd_rs_d !== 2'd1) begin n_fail++; $display("FAIL jal_nop_fwd: got %0d want 1", hz.fwd_rs_d); end
        tick();
        flush();
    endtask

    task automatic test_store_data();
        drive(enc_i(35, 0, 4, 0));
        tick();
        drive(enc_i(43, 5, 4, 0));
        n_cmp++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL sw_stall: got %0b want 0", hz.stall); end
        tick();
        drive(32'd0);
        n_cmp++; if (hz.fwd_rt_e !== 2'd0) begin n_fail++; $display("FAIL sw_fwd_rt_e: got %0d want 0", hz.fwd_rt_e); end
        tick();
        drive(32'd0);
        n_cmp++; if (hz.fwd_rt_m !== 2'd2) begin n_fail++; $display("FAIL sw_fwd_rt_m: got %0d want 2", hz.fwd_rt_m); end
        tick();
        flush();
    endtask

    task automatic test_reg_zero();
        drive(enc_r(33, 0, 1, 2));
        tick();
        drive(enc_r(33, 6, 0, 0));
        n_cmp++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %0b want 0", hz.stall); end
        n_cmp++; if (hz.fwd_rs_d !== 2'd0) begin n_fail++; $display("FAIL r0_fwd_rs_d: got %0d want 0", hz.fwd_rs_d); end
        n_cmp++; if (hz.fwd_rt_d !== 2'd0) begin n_fail++; $display("FAIL r0_fwd_rt_d: got %0d want 0", hz.fwd_rt_d); end
        tick();
        drive(32'd0);
        n_cmp++; if (hz.fwd_rs_e !== 2'd0) begin n_fail++; $display("FAIL r0_fwd_rs_e: got %0d want 0", hz.fwd_rs_e); end
        n_cmp++; if (hz.fwd_rt_e !== 2'd0) begin n_fail++; $display("FAIL r0_fwd_rt_e: got %0d want 0", hz.fwd_rt_e); end
        tick();
        flush();
    endtask

    task automatic test_same_regs();
        drive(enc_i(13, 0, 7, 1));
        tick();
        drive(enc_i(4, 7, 7, 1));
        n_cmp++; if (hz.stall !== 1'b1) begin n_fail++; $display("FAIL same_stall: got %0b want 1", hz.stall); end
        tick();
        drive(enc_i(4, 7, 7, 1));
        n_cmp++; if (hz.fwd_rs_d !== 2'd1) begin n_fail++; $display("FAIL same_fwd_rs_d: got %0d want 1", hz.fwd_rs_d); end
        n_cmp++; if (hz.fwd_rt_d !== 2'd1) begin n_fail++; $display("FAIL same_fwd_rt_d: got %0d want 1", hz.fwd_rt_d); end
        tick();
        flush();
    endtask

    task automatic test_reset_mid_stall();
        drive(enc_i(35, 0, 1, 0));
        tick();
        drive(enc_r(33, 2, 1, 1));
        n_cmp++; if (hz.stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre_stall: got %0b want 1", hz.stall); end
        #2;
        reset_n = 1'b0;
        m_clear();
        #1;
        n_cmp++; if (hz.stall !== 1'b0) begin n_fail++; $display("FAIL rst_async_stall: got %0b want 0", hz.stall); end
        n_cmp++; if ({hz.fwd_rs_d, hz.fwd_rt_d, hz.fwd_rs_e, hz.fwd_rt_e, hz.fwd_rt_m} !== 10'd0) begin
            n_fail++;
            $display("FAIL rst_async_fwd: got %0h want 0",
                     {hz.fwd_rs_d, hz.fwd_rt_d, hz.fwd_rs_e, hz.fwd_rt_e, hz.fwd_rt_m});
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        test_load_use();
    endtask

    task automatic test_random();
        logic [31:0] ins;
        int hold;
        ins = rand_instr();
        for (int c = 0; c < 400; c++) begin
            drive(ins);
            n_cmp++; if (hz.stall !== 1'(e_stall)) begin n_fail++; $display("FAIL rnd_stall c=%0d ins=%h: got %0b want %0d", c, ins, hz.stall, e_stall); end
            n_cmp++; if (hz.fwd_rs_d !== 2'(e_fd_rs)) begin n_fail++; $display("FAIL rnd_fwd_rs_d c=%0d ins=%h: got %0d want %0d", c, ins, hz.fwd_rs_d, e_fd_rs); end
            n_cmp++; if (hz.fwd_rt_d !== 2'(e_fd_rt)) begin n_fail++; $display("FAIL rnd_fwd_rt_d c=%0d ins=%h: got %0d want %0d", c, ins, hz.fwd_rt_d, e_fd_rt); end
            n_cmp++; if (hz.fwd_rs_e !== 2'(e_fe_rs)) begin n_fail++; $display("FAIL rnd_fwd_rs_e c=%0d: got %0d want %0d", c, hz.fwd_rs_e, e_fe_rs); end
            n_cmp++; if (hz.fwd_rt_e !== 2'(e_fe_rt)) begin n_fail++; $display("FAIL rnd_fwd_rt_e c=%0d: got %0d want %0d", c, hz.fwd_rt_e, e_fe_rt); end
            n_cmp++; if (hz.fwd_rt_m !== 2'(e_fm_rt)) begin n_fail++; $display("FAIL rnd_fwd_rt_m c=%0d: got %0d want %0d", c, hz.fwd_rt_m, e_fm_rt); end
            hold = e_stall;
            tick();
            if (hold == 0) ins = rand_instr();
        end
        flush();
    endtask

    initial begin
        reset_n     = 1'b0;
        hz.id_instr = 32'd0;
        cur         = 32'd0;
        m_clear();
        test_reset();
        test_load_use();
        test_branch();
        test_jal_jr();
        test_store_data();
        test_reg_zero();
        test_same_regs();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
`default_nettype wire
